// File: rtl/date_feed_ctrl.sv
// rtl/date_feed_ctrl.sv - two-requester round-robin byte feeder for a shared date checker
// Strips leading NULs, forwards bytes up to '@', then reports checker result, length and overflow.
module date_feed_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [15:0] req_data,
  output logic [1:0]  req_ready,
  output logic [7:0]  chk_in,
  output logic        chk_vld,
  output logic        chk_clr,
  input  logic        chk_out,
  output logic        done,
  output logic        done_id,
  output logic        match,
  output logic [7:0]  len,
  output logic        ovf
);
  typedef enum logic [2:0] {S_IDLE, S_CLR, S_FEED, S_WAIT, S_REPORT} state_t;

  state_t     r_state, w_next;
  logic       r_prio, r_gid, r_seen_nz, r_ovf_acc;
  logic [7:0] r_cnt;
  logic [7:0] w_byte;
  logic       w_start, w_gnt_sel, w_accept, w_term, w_fwd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 2'b00;
    w_start   = 1'b0;
    w_accept  = 1'b0;
    w_term    = 1'b0;
    w_fwd     = 1'b0;
    // The prio requester wins a tie; otherwise whoever is valid takes the grant.
    w_gnt_sel = req_valid[r_prio] ? r_prio : ~r_prio;
    w_byte    = r_gid ? req_data[15:8] : req_data[7:0];
    case (r_state)
      S_IDLE: begin
        w_start = |req_valid;
        if (w_start) w_next = S_CLR;
      end
      S_CLR:  w_next = S_FEED;
      S_FEED: begin
        req_ready[r_gid] = 1'b1;
        w_accept = req_valid[r_gid];
        w_term   = w_accept && (w_byte == 8'h40);
        w_fwd    = w_accept && !w_term && (r_seen_nz || (w_byte != 8'h00));
        if (w_term) w_next = S_WAIT;
      end
      S_WAIT:   w_next = S_REPORT;
      S_REPORT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prio    <= 1'b0;
      r_gid     <= 1'b0;
      r_seen_nz <= 1'b0;
      r_ovf_acc <= 1'b0;
      r_cnt     <= 8'h00;
      chk_in    <= 8'h00;
      chk_vld   <= 1'b0;
      chk_clr   <= 1'b0;
      done      <= 1'b0;
      done_id   <= 1'b0;
      match     <= 1'b0;
      len       <= 8'h00;
      ovf       <= 1'b0;
    end else begin
      chk_vld <= w_fwd;
      chk_in  <= w_fwd ? w_byte : 8'h00;
      chk_clr <= w_start;
      done    <= (r_state == S_REPORT);
      if (w_start) r_gid <= w_gnt_sel;
      if (r_state == S_CLR) begin
        r_cnt     <= 8'h00;
        r_seen_nz <= 1'b0;
        r_ovf_acc <= 1'b0;
      end
      if (w_fwd) begin
        r_seen_nz <= 1'b1;
        if (r_cnt == 8'hFF) r_ovf_acc <= 1'b1;
        else                r_cnt     <= r_cnt + 8'h01;
      end
      // By REPORT the checker has seen the last forwarded byte for a full cycle.
      if (r_state == S_REPORT) begin
        match   <= chk_out;
        len     <= r_cnt;
        ovf     <= r_ovf_acc;
        done_id <= r_gid;
        r_prio  <= ~r_gid;
      end
    end
  end
endmodule

// File: tb/tb_date_feed_ctrl.sv
// tb/tb_date_feed_ctrl.sv - randomized scoreboard bench for date_feed_ctrl
// Frame-level model predicts grant order, forwarded bytes and per-frame results.
module tb_date_feed_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  req_valid, req_ready;
  logic [15:0] req_data;
  logic [7:0]  chk_in, len;
  logic        chk_vld, chk_clr, chk_out, done, done_id, match, ovf;

  logic       dv[2] = '{1'b0, 1'b0};
  logic [7:0] dd[2] = '{8'h00, 8'h00};
  assign req_valid = {dv[1], dv[0]};
  assign req_data  = {dd[1], dd[0]};

  date_feed_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .chk_in(chk_in), .chk_vld(chk_vld), .chk_clr(chk_clr),
    .chk_out(chk_out), .done(done), .done_id(done_id), .match(match), .len(len), .ovf(ovf)
  );

  // Checker stand-in: match = odd parity of the XOR of all bytes since the last clear.
  logic [7:0] chk_acc;
  always @(posedge clk or posedge reset) begin
    if (reset)        chk_acc <= 8'h00;
    else if (chk_clr) chk_acc <= 8'h00;
    else if (chk_vld) chk_acc <= chk_acc ^ chk_in;
  end
  assign chk_out = ^chk_acc;

  typedef struct packed {logic id; logic [7:0] len; logic ovf; logic match;} res_t;
  typedef logic [7:0] bq_t[$];

  int n_cmp = 0, n_bad = 0;
  logic [7:0] exp_bytes[$];
  res_t       exp_res[$];
  logic [7:0] pf0[$], pf1[$];
  int         pn0[$], pn1[$];
  logic       mprio = 1'b0;
  logic       seen_ids[$];
  int         vld_count = 0, clr_count = 0, done_count = 0;
  res_t       held = '0;
  res_t       last = '0;

  logic [7:0] mem[2][8192];
  int  head[2] = '{0, 0}, tail[2] = '{0, 0}, acc[2] = '{0, 0};
  int  drv_stall[2] = '{0, 0}, stall_at[2] = '{-1, -1};
  bit  drv_start[2] = '{1'b1, 1'b1};
  bit  rand_stall = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int k = 0; k < s.len(); k++) q.push_back(s[k]);
    return q;
  endfunction

  task automatic add_frame(input int i, input bq_t p);
    bit seen = 1'b0;
    int n = 0;
    foreach (p[k]) begin
      mem[i][tail[i]] = p[k];
      tail[i]++;
      if (p[k] != 8'h00) seen = 1'b1;
      if (seen) begin
        if (i == 0) pf0.push_back(p[k]); else pf1.push_back(p[k]);
        n++;
      end
    end
    mem[i][tail[i]] = 8'h40;
    tail[i]++;
    if (i == 0) pn0.push_back(n); else pn1.push_back(n);
  endtask

  // Both requesters keep frames queued back to back, so the grant order follows from pending counts.
  task automatic schedule();
    while (pn0.size() + pn1.size() > 0) begin
      logic id;
      int n;
      logic [7:0] x, b;
      res_t r;
      if (pn0.size() > 0 && pn1.size() > 0) id = mprio;
      else id = (pn0.size() > 0) ? 1'b0 : 1'b1;
      n = (id == 1'b0) ? pn0.pop_front() : pn1.pop_front();
      x = 8'h00;
      for (int k = 0; k < n; k++) begin
        b = (id == 1'b0) ? pf0.pop_front() : pf1.pop_front();
        exp_bytes.push_back(b);
        x ^= b;
      end
      r.id = id;
      r.len = (n > 255) ? 8'hFF : 8'(n);
      r.ovf = (n > 255);
      r.match = ^x;
      exp_res.push_back(r);
      mprio = ~id;
    end
  endtask

  task automatic rand_frame(input int i);
    bq_t p;
    int n = $urandom_range(0, 20);
    int z = $urandom_range(0, 2);
    logic [7:0] b;
    for (int k = 0; k < z; k++) p.push_back(8'h00);
    for (int k = 0; k < n; k++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'h40) b = 8'h41;
      if ($urandom_range(0, 7) == 0) b = 8'h00;
      p.push_back(b);
    end
    add_frame(i, p);
  endtask

  task automatic drive(input int i);
    forever begin
      @(negedge clk);
      if (reset || head[i] == tail[i]) dv[i] = 1'b0;
      else if (drv_stall[i] > 0) begin dv[i] = 1'b0; drv_stall[i]--; end
      else if (!drv_start[i] && stall_at[i] == acc[i]) begin
        dv[i] = 1'b0; drv_stall[i] = 4; stall_at[i] = -1;
      end else if (!drv_start[i] && rand_stall && $urandom_range(0, 5) == 0) begin
        dv[i] = 1'b0; drv_stall[i] = int'($urandom_range(0, 3));
      end else begin
        dv[i] = 1'b1; dd[i] = mem[i][head[i]];
      end
      if (!dv[i]) dd[i] = 8'($urandom_range(0, 255));
      #1;
      if (dv[i] && req_ready[i]) begin
        drv_start[i] = (dd[i] == 8'h40);
        head[i]++;
        acc[i]++;
      end
    end
  endtask
  initial drive(0);
  initial drive(1);

  always @(negedge clk) begin
    if (reset) begin
      check("rst_ready", 32'(req_ready), 0);
      check("rst_chk_in", 32'(chk_in), 0);
      check("rst_chk_vld", 32'(chk_vld), 0);
      check("rst_chk_clr", 32'(chk_clr), 0);
      check("rst_done", 32'(done), 0);
      check("rst_held", 32'({done_id, len, ovf, match}), 0);
      held = '0;
    end else begin
      if (chk_vld) begin
        vld_count++;
        if (exp_bytes.size() == 0) check("vld_unexpected", 32'(chk_vld), 0);
        else check("chk_in", 32'(chk_in), 32'(exp_bytes.pop_front()));
      end else check("chk_in_idle", 32'(chk_in), 0);
      if (chk_clr) clr_count++;
      if (req_ready != 2'b00) begin
        if (exp_res.size() == 0) check("ready_unexpected", 32'(req_ready), 0);
        else check("ready_owner", 32'(req_ready), 32'(2'b01 << exp_res[0].id));
      end
      if (done) begin
        done_count++;
        last = '{id: done_id, len: len, ovf: ovf, match: match};
        seen_ids.push_back(done_id);
        if (exp_res.size() == 0) check("done_unexpected", 32'(done), 0);
        else begin
          held = exp_res.pop_front();
          check("done_id", 32'(done_id), 32'(held.id));
          check("len", 32'(len), 32'(held.len));
          check("ovf", 32'(ovf), 32'(held.ovf));
          check("match", 32'(match), 32'(held.match));
        end
      end else check("held_result", 32'({done_id, len, ovf, match}), 32'(held));
    end
  end

  task automatic wait_done(input int budget);
    int t = 0;
    while (exp_res.size() > 0 && t < budget) begin @(posedge clk); t++; end
    if (exp_res.size() > 0) begin
      check("frame_timeout", 32'(exp_res.size()), 0);
      exp_res.delete(); exp_bytes.delete();
      head[0] = tail[0]; head[1] = tail[1];
    end
    repeat (3) @(posedge clk);
    #2;
  endtask

  initial begin
    int base_v, base_c, base_d;
    // Contention straight out of reset: expect 0,1,0,1.
    for (int k = 0; k < 2; k++) begin rand_frame(0); rand_frame(1); end
    schedule();
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    wait_done(2000);
    check("contend_n", 32'(seen_ids.size()), 4);
    for (int k = 0; k < 4 && k < seen_ids.size(); k++)
      check("contend_order", 32'(seen_ids[k]), 32'(k % 2));

    base_v = vld_count;
    add_frame(0, {8'h00, 8'h00, str2q("2020.11.10")});
    schedule();
    wait_done(500);
    check("date_len", 32'(last.len), 10);
    check("date_match", 32'(last.match), 1);
    check("date_id", 32'(last.id), 0);
    check("date_vld_count", 32'(vld_count - base_v), 10);

    base_v = vld_count; base_c = clr_count;
    add_frame(1, str2q(""));
    schedule();
    wait_done(500);
    check("empty_len", 32'(last.len), 0);
    check("empty_id", 32'(last.id), 1);
    check("empty_vld_count", 32'(vld_count - base_v), 0);
    check("empty_clr_count", 32'(clr_count - base_c), 1);

    stall_at[0] = acc[0] + 4;
    add_frame(0, str2q("1999.12.31"));
    schedule();
    wait_done(500);
    check("stall_len", 32'(last.len), 10);

    begin
      bq_t p;
      for (int k = 0; k < 300; k++) p.push_back(8'h41 + 8'(k % 26));
      add_frame(0, p);
    end
    schedule();
    wait_done(2000);
    check("sat_len", 32'(last.len), 255);
    check("sat_ovf", 32'(last.ovf), 1);

    rand_stall = 1'b1;
    for (int b = 0; b < 8; b++) begin
      int n0 = $urandom_range(0, 3);
      int n1 = $urandom_range(0, 3);
      for (int k = 0; k < 3; k++) begin
        if (k < n0) rand_frame(0);
        if (k < n1) rand_frame(1);
      end
      schedule();
      wait_done(4000);
    end
    rand_stall = 1'b0;

    // Reset after four forwarded bytes aborts the frame without a report.
    base_v = vld_count; base_d = done_count;
    add_frame(0, str2q("ABCDEFGH"));
    schedule();
    for (int t = 0; t < 200 && vld_count < base_v + 4; t++) begin @(negedge clk); #1; end
    #1 reset = 1'b1;
    exp_bytes.delete(); exp_res.delete();
    head[0] = tail[0]; drv_start[0] = 1'b1; drv_stall[0] = 0; mprio = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    check("abort_vld_count", 32'(vld_count - base_v), 4);
    check("abort_no_done", 32'(done_count - base_d), 0);
    @(posedge clk);
    #2;
    add_frame(0, str2q("XY"));
    schedule();
    wait_done(500);
    check("post_reset_len", 32'(last.len), 2);
    check("post_reset_id", 32'(last.id), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
